cic_tx_ctrl: RTL

Sequencer for the transmit CIC interpolator (`cic_tx_wrapper`). On a start pulse it programs the interpolation rate through the CIC config channel and waits a settle period. It then streams a frame of packed I/Q sample pairs into the CIC's single 16-bit data port as interleaved I, Q beats at a programmable beat interval, asserting tlast on the final Q. It sits between the IFFT sample source and the CIC, replacing bench-driven pacing.

---
 rtl/cic_tx_pkg.sv | 26 ++
 rtl/cic_pace_timer.sv | 27 ++
 rtl/cic_tx_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cic_tx_pkg.sv
// Shared types and constants for the transmit CIC sequencer.
package cic_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_SETTLE,
        ST_I_BEAT,
        ST_GAP_I,
        ST_Q_BEAT,
        ST_GAP_Q,
        ST_DONE
    } state_t;

    localparam int RATE_DEF     = 40;
    localparam int INTERVAL_DEF = 200;
    localparam int SETTLE_DEF   = 30;

    // Shortest beat spacing; each gap state needs at least one cycle.
    localparam int MIN_INTERVAL = 2;

    // Rail slots inside a packed I/Q word; the bit offset is slot * DATA_W.
    localparam int IQ_I_SLOT = 0;
    localparam int IQ_Q_SLOT = 1;

endpackage

// File: rtl/cic_pace_timer.sv
// Down-counter reloaded on every handshake; expire marks the last cycle of the wait.
module cic_pace_timer #(
    parameter int CNT_W = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/cic_tx_ctrl.sv
// Transmit CIC sequencer: programs the interpolation rate, waits a settle period,
// then paces interleaved I/Q beats from a one-pair buffer into the CIC data port.
module cic_tx_ctrl
    import cic_tx_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = SETTLE_DEF
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                start,
    input  logic [15:0]         cfg_rate,
    input  logic [CNT_W-1:0]    cfg_interval,
    input  logic [CNT_W-1:0]    cfg_num_pairs,
    input  logic [2*DATA_W-1:0] s_axis_iq_tdata,
    input  logic                s_axis_iq_tvalid,
    output logic                s_axis_iq_tready,
    output logic [15:0]         m_axis_config_tdata,
    output logic                m_axis_config_tvalid,
    input  logic                m_axis_config_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    underrun_cnt
);

    state_t              state, state_nxt;
    logic [15:0]         rate_q;
    logic [CNT_W-1:0]    interval_q, num_pairs_q, pair_idx, fetch_cnt;
    logic [2*DATA_W-1:0] pair_buf;
    logic                buf_full, starve_seen;
    logic                start_acc, cfg_hs, i_hs, q_hs, src_hs;
    logic                tmr_load, tmr_expire;
    logic [CNT_W-1:0]    tmr_load_val;

    assign start_acc = (state == ST_IDLE) && start;
    assign cfg_hs    = (state == ST_CFG) && m_axis_config_tready;
    assign i_hs      = (state == ST_I_BEAT) && buf_full && m_axis_tready;
    assign q_hs      = (state == ST_Q_BEAT) && m_axis_tready;
    assign src_hs    = s_axis_iq_tvalid && s_axis_iq_tready;

    // Fetching stops once the frame's pairs are in, so no sample of the next frame is consumed.
    assign s_axis_iq_tready    = busy && !buf_full && (fetch_cnt != num_pairs_q);
    assign m_axis_config_tdata = rate_q;

    // Pacing restarts at each handshake, so a stalled beat pushes all later beats out.
    assign tmr_load     = cfg_hs || i_hs || q_hs;
    assign tmr_load_val = cfg_hs ? CNT_W'(SETTLE_CYCLES) : interval_q - CNT_W'(1);

    cic_pace_timer #(.CNT_W(CNT_W)) u_pace_timer (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .expire   (tmr_expire)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        state_nxt            = state;
        m_axis_config_tvalid = 1'b0;
        m_axis_tvalid        = 1'b0;
        m_axis_tlast         = 1'b0;
        m_axis_tdata         = pair_buf[IQ_I_SLOT*DATA_W +: DATA_W];
        busy                 = 1'b1;
        done                 = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_CFG;
            end
            ST_CFG: begin
                m_axis_config_tvalid = 1'b1;
                if (m_axis_config_tready) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: if (tmr_expire) state_nxt = ST_I_BEAT;
            ST_I_BEAT: begin
                m_axis_tvalid = buf_full;
                if (i_hs) state_nxt = ST_GAP_I;
            end
            ST_GAP_I: if (tmr_expire) state_nxt = ST_Q_BEAT;
            ST_Q_BEAT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = pair_buf[IQ_Q_SLOT*DATA_W +: DATA_W];
                m_axis_tlast  = (pair_idx == num_pairs_q - CNT_W'(1));
                if (m_axis_tready) state_nxt = ST_GAP_Q;
            end
            ST_GAP_Q: begin
                if (tmr_expire) state_nxt = (pair_idx == num_pairs_q) ? ST_DONE : ST_I_BEAT;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rate_q      <= '0;
            interval_q  <= '0;
            num_pairs_q <= '0;
            pair_idx    <= '0;
            fetch_cnt   <= '0;
        end else if (start_acc) begin
            rate_q      <= cfg_rate;
            interval_q  <= (cfg_interval < CNT_W'(MIN_INTERVAL)) ? CNT_W'(MIN_INTERVAL) : cfg_interval;
            num_pairs_q <= (cfg_num_pairs == '0) ? CNT_W'(1) : cfg_num_pairs;
            pair_idx    <= '0;
            fetch_cnt   <= '0;
        end else begin
            if (q_hs)   pair_idx  <= pair_idx + CNT_W'(1);
            if (src_hs) fetch_cnt <= fetch_cnt + CNT_W'(1);
        end
    end

    // NOTE: the pair buffer is reset too, because m_axis_tdata reads straight from it and must be zero out of reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pair_buf <= '0;
            buf_full <= 1'b0;
        end else if (q_hs) begin
            buf_full <= 1'b0;
        end else if (src_hs) begin
            pair_buf <= s_axis_iq_tdata;
            buf_full <= 1'b1;
        end
    end

    // A starved I slot is counted once, on its first cycle, however long it waits.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            underrun_cnt <= '0;
            starve_seen  <= 1'b0;
        end else begin
            starve_seen <= (state == ST_I_BEAT) && (starve_seen || !buf_full);
            if (start_acc) begin
                underrun_cnt <= '0;
            end else if ((state == ST_I_BEAT) && !buf_full && !starve_seen && (underrun_cnt != '1)) begin
                underrun_cnt <= underrun_cnt + CNT_W'(1);
            end
        end
    end

endmodule
